// File: rtl/logic_arbiter.sv
// Two-requester round-robin arbiter in front of one shared logic unit.
// One operation in flight; lu_out is captured LU_LAT cycles after operands load.
module logic_arbiter #(
    parameter int LU_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic       req1_valid,
    output logic       req0_ready,
    output logic       req1_ready,
    input  logic [3:0] req0_x,
    input  logic [3:0] req0_y,
    input  logic [3:0] req1_x,
    input  logic [3:0] req1_y,
    input  logic [1:0] req0_sel,
    input  logic [1:0] req1_sel,
    output logic       rsp0_valid,
    output logic       rsp1_valid,
    input  logic       rsp0_ready,
    input  logic       rsp1_ready,
    output logic [7:0] rsp0_data,
    output logic [7:0] rsp1_data,
    output logic [3:0] lu_x,
    output logic [3:0] lu_y,
    output logic [1:0] lu_sel,
    input  logic [7:0] lu_out,
    output logic       busy,
    output logic [7:0] ops_done
);
    localparam logic [3:0] CNT_INIT = 4'(LU_LAT - 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state, state_nx;
    logic       last;
    logic       gnt;
    logic       pick;
    logic       accept;
    logic       rsp_hs;
    logic [3:0] cnt;
    logic [7:0] res;

    // last holds the index served most recently; reset to 1 so req0 wins the first tie
    assign pick = req1_valid & (~req0_valid | ~last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        accept     = 1'b0;
        rsp_hs     = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                req0_ready = req0_valid & ~pick;
                req1_ready = pick;
                accept     = req0_valid | req1_valid;
                if (accept) state_nx = EXEC;
            end
            EXEC: begin
                if (cnt == 4'd0) state_nx = RESP;
            end
            RESP: begin
                rsp0_valid = ~gnt;
                rsp1_valid = gnt;
                rsp_hs     = gnt ? rsp1_ready : rsp0_ready;
                if (rsp_hs) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_x     <= 4'd0;
            lu_y     <= 4'd0;
            lu_sel   <= 2'd0;
            last     <= 1'b1;
            gnt      <= 1'b0;
            cnt      <= 4'd0;
            res      <= 8'd0;
            ops_done <= 8'd0;
        end else begin
            if (accept) begin
                lu_x   <= pick ? req1_x   : req0_x;
                lu_y   <= pick ? req1_y   : req0_y;
                lu_sel <= pick ? req1_sel : req0_sel;
                gnt    <= pick;
                cnt    <= CNT_INIT;
            end
            if (state == EXEC) begin
                if (cnt == 4'd0) res <= lu_out;
                else             cnt <= cnt - 4'd1;
            end
            if (rsp_hs) begin
                last     <= gnt;
                ops_done <= ops_done + 8'd1;
            end
        end
    end

    // Only the granted side shows the result; the other reads zero
    assign rsp0_data = rsp0_valid ? res : 8'd0;
    assign rsp1_data = rsp1_valid ? res : 8'd0;

endmodule
